// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the instruction-fetch / data-port bus arbiter.
// Holds the default bus widths, starvation and timeout limits, the FSM
// state encoding and a small state-decode helper.
package bus_arbiter_pkg;

   localparam int unsigned BA_ADDR_W       = 32;
   localparam int unsigned BA_DATA_W       = 32;
   localparam int unsigned BA_STARVE_LIMIT = 4;
   localparam int unsigned BA_TIMEOUT      = 255;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_BUSY_IF  = 2'd1,
      ST_BUSY_MEM = 2'd2,
      ST_RESP     = 2'd3
   } arb_state_e;

   function automatic logic is_busy(input arb_state_e s);
      return (s == ST_BUSY_IF) || (s == ST_BUSY_MEM);
   endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Signal bundle between the arbiter and its surroundings.
//   fetch port : if_req_i, if_addr_i -> if_data_o, if_ack_o
//   data port  : mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_be_i
//                -> mem_rdata_o, mem_ack_o
//   shared bus : bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o
//                <- bus_rdata_i, bus_ack_i
//   status     : hold_req_o (stall request), bus_err_o (sticky timeout)
// Modport slave is the arbiter's view; modport master is the view of the
// requesters and memory slave around it.
interface bus_arbiter_if
   import bus_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = BA_ADDR_W,
   parameter int unsigned DATA_W = BA_DATA_W
) ();

   logic                  if_req_i;
   logic [ADDR_W-1:0]     if_addr_i;
   logic [DATA_W-1:0]     if_data_o;
   logic                  if_ack_o;

   logic                  mem_req_i;
   logic                  mem_we_i;
   logic [ADDR_W-1:0]     mem_addr_i;
   logic [DATA_W-1:0]     mem_wdata_i;
   logic [DATA_W/8-1:0]   mem_be_i;
   logic [DATA_W-1:0]     mem_rdata_o;
   logic                  mem_ack_o;

   logic                  bus_req_o;
   logic                  bus_we_o;
   logic [ADDR_W-1:0]     bus_addr_o;
   logic [DATA_W-1:0]     bus_wdata_o;
   logic [DATA_W/8-1:0]   bus_be_o;
   logic [DATA_W-1:0]     bus_rdata_i;
   logic                  bus_ack_i;

   logic                  hold_req_o;
   logic                  bus_err_o;

   modport slave (
      input  if_req_i, if_addr_i,
      input  mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_be_i,
      input  bus_rdata_i, bus_ack_i,
      output if_data_o, if_ack_o,
      output mem_rdata_o, mem_ack_o,
      output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o,
      output hold_req_o, bus_err_o
   );

   modport master (
      output if_req_i, if_addr_i,
      output mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_be_i,
      output bus_rdata_i, bus_ack_i,
      input  if_data_o, if_ack_o,
      input  mem_rdata_o, mem_ack_o,
      input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o,
      input  hold_req_o, bus_err_o
   );

endinterface

// File: rtl/bus_arbiter_timeout_cnt.sv
// Bus transaction watchdog (module bus_timeout_cnt).
// Ports: clk, rst (sync, active-high), i_clear (transaction start),
//        i_busy (a bus request is outstanding), o_expire (this busy cycle
//        is the TIMEOUT-th one without completion).
module bus_timeout_cnt
   import bus_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT = BA_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_busy,
   output logic o_expire
);
   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_cnt <= '0;
      end else if (i_busy) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   // r_cnt counts completed busy cycles, so the current cycle is number r_cnt+1.
   assign o_expire = i_busy && (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter for a shared memory bus: an instruction-fetch read port
// and a read/write data port. Data normally wins; a starvation counter
// forces a fetch grant after STARVE_LIMIT data grants made while fetch
// waited. A watchdog aborts transactions the slave never acknowledges and
// raises a sticky error.
// Ports: clk, rst (sync, active-high), bif (bus_arbiter_if.slave bundle).
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W       = BA_ADDR_W,
   parameter int unsigned DATA_W       = BA_DATA_W,
   parameter int unsigned STARVE_LIMIT = BA_STARVE_LIMIT,
   parameter int unsigned TIMEOUT      = BA_TIMEOUT
) (
   input  logic         clk,
   input  logic         rst,
   bus_arbiter_if.slave bif
);
   localparam int unsigned   BE_W       = DATA_W / 8;
   localparam int unsigned   SW         = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   arb_state_e          r_state;
   arb_state_e          w_state_nx;

   logic                r_gnt_mem;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [BE_W-1:0]     r_be;
   logic [DATA_W-1:0]   r_rdata;
   logic [SW-1:0]       r_starve;
   logic                r_err;

   logic                w_gnt_if;
   logic                w_gnt_mem;
   logic                w_done;
   logic                w_abort;
   logic                w_busy;
   logic                w_expire;
   logic                w_if_ack;
   logic                w_mem_ack;

   assign w_busy = is_busy(r_state);

   // Next state and grant decode
   always_comb begin
      w_state_nx = r_state;
      w_gnt_if   = 1'b0;
      w_gnt_mem  = 1'b0;
      w_done     = 1'b0;
      w_abort    = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (bif.mem_req_i && !(bif.if_req_i && (r_starve == STARVE_MAX))) begin
               w_gnt_mem  = 1'b1;
               w_state_nx = ST_BUSY_MEM;
            end else if (bif.if_req_i) begin
               w_gnt_if   = 1'b1;
               w_state_nx = ST_BUSY_IF;
            end
         end
         ST_BUSY_IF, ST_BUSY_MEM: begin
            // A slave ack in the expiry cycle still completes normally.
            if (bif.bus_ack_i) begin
               w_done     = 1'b1;
               w_state_nx = ST_RESP;
            end else if (w_expire) begin
               w_abort    = 1'b1;
               w_state_nx = ST_RESP;
            end
         end
         ST_RESP: begin
            w_state_nx = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   // Request latches, response data, starvation counter, error flag
   always_ff @(posedge clk) begin
      if (rst) begin
         r_gnt_mem <= 1'b0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_be      <= '0;
         r_rdata   <= '0;
         r_starve  <= '0;
         r_err     <= 1'b0;
      end else begin
         if (w_gnt_mem) begin
            r_gnt_mem <= 1'b1;
            r_we      <= bif.mem_we_i;
            r_addr    <= bif.mem_addr_i;
            r_wdata   <= bif.mem_wdata_i;
            r_be      <= bif.mem_be_i;
            if (bif.if_req_i && (r_starve != STARVE_MAX)) begin
               r_starve <= r_starve + SW'(1);
            end
         end
         if (w_gnt_if) begin
            r_gnt_mem <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= bif.if_addr_i;
            r_wdata   <= '0;
            r_be      <= '1;
            r_starve  <= '0;
         end
         if (w_done) begin
            r_rdata <= r_we ? '0 : bif.bus_rdata_i;
         end
         if (w_abort) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
         end
      end
   end

   bus_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk      (clk),
      .rst      (rst),
      .i_clear  (w_gnt_if | w_gnt_mem),
      .i_busy   (w_busy),
      .o_expire (w_expire)
   );

   assign w_if_ack  = (r_state == ST_RESP) && !r_gnt_mem;
   assign w_mem_ack = (r_state == ST_RESP) &&  r_gnt_mem;

   assign bif.if_ack_o    = w_if_ack;
   assign bif.mem_ack_o   = w_mem_ack;
   assign bif.if_data_o   = w_if_ack  ? r_rdata : '0;
   assign bif.mem_rdata_o = w_mem_ack ? r_rdata : '0;

   assign bif.bus_req_o   = w_busy;
   assign bif.bus_we_o    = r_we;
   assign bif.bus_addr_o  = r_addr;
   assign bif.bus_wdata_o = r_wdata;
   assign bif.bus_be_o    = r_be;
   assign bif.bus_err_o   = r_err;

   assign bif.hold_req_o  = (bif.if_req_i & ~w_if_ack) | (bif.mem_req_i & ~w_mem_ack);

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed transactions, a
// transaction-level reference model checked every cycle, and literal
// expectations for latency, grant order, timeout and reset behaviour.
module tb_bus_arbiter;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int BEW = DW / 8;
   localparam int LIM = 4;
   localparam int TMO = 255;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();

   bus_arbiter #(
      .ADDR_W       (AW),
      .DATA_W       (DW),
      .STARVE_LIMIT (LIM),
      .TIMEOUT      (TMO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bif (bif.slave)
   );

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: actual=0x%0h required=0x%0h", nm, $time, act, exp);
      end
   endtask

   // ---------------- memory slave responder ----------------
   int              slave_lat  = 0;   // ack in busy cycle slave_lat+1; -1 = never
   logic            spur       = 1'b0;
   logic [DW-1:0]   slave_data = '0;
   int              n_busy     = 0;

   initial begin
      bif.bus_ack_i   = 1'b0;
      bif.bus_rdata_i = '0;
      forever begin
         @(posedge clk);
         #2;
         if (bif.bus_req_o === 1'b1) n_busy++;
         else n_busy = 0;
         bif.bus_ack_i = spur ||
            ((slave_lat >= 0) && (bif.bus_req_o === 1'b1) && (n_busy == slave_lat + 1));
         bif.bus_rdata_i = slave_data;
      end
   end

   // ---------------- reference model ----------------
   // owner/resp: 0 none, 1 fetch, 2 data
   int              m_owner  = 0;
   int              m_resp   = 0;
   int              m_wait   = 0;
   int              m_starve = 0;
   logic            m_err    = 1'b0;
   logic            m_valid  = 1'b0;
   logic            m_we     = 1'b0;
   logic [AW-1:0]   m_addr   = '0;
   logic [DW-1:0]   m_wdata  = '0;
   logic [BEW-1:0]  m_be     = '0;
   logic [DW-1:0]   m_rdata  = '0;
   bit              take_mem;
   int              grants[$];

   always @(posedge clk) begin
      if (rst) begin
         m_owner  = 0;
         m_resp   = 0;
         m_wait   = 0;
         m_starve = 0;
         m_err    = 1'b0;
         m_rdata  = '0;
         m_valid  = 1'b1;
      end else if (m_resp != 0) begin
         m_resp = 0;
      end else if (m_owner != 0) begin
         m_wait++;
         if (bif.bus_ack_i) begin
            m_resp  = m_owner;
            m_rdata = m_we ? '0 : bif.bus_rdata_i;
            m_owner = 0;
         end else if (m_wait == TMO) begin
            m_resp  = m_owner;
            m_rdata = '0;
            m_err   = 1'b1;
            m_owner = 0;
         end
      end else begin
         take_mem = bif.mem_req_i && !(bif.if_req_i && (m_starve == LIM));
         if (take_mem) begin
            m_owner = 2;
            m_we    = bif.mem_we_i;
            m_addr  = bif.mem_addr_i;
            m_wdata = bif.mem_wdata_i;
            m_be    = bif.mem_be_i;
            if (bif.if_req_i) m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
            m_wait  = 0;
            grants.push_back(2);
         end else if (bif.if_req_i) begin
            m_owner  = 1;
            m_we     = 1'b0;
            m_addr   = bif.if_addr_i;
            m_be     = '1;
            m_starve = 0;
            m_wait   = 0;
            grants.push_back(1);
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (m_valid) begin
         check("bus_req", 64'(bif.bus_req_o), 64'(m_owner != 0));
         check("if_ack", 64'(bif.if_ack_o), 64'(m_resp == 1));
         check("mem_ack", 64'(bif.mem_ack_o), 64'(m_resp == 2));
         check("bus_err", 64'(bif.bus_err_o), 64'(m_err));
         check("hold_req", 64'(bif.hold_req_o),
               64'((bif.if_req_i && (m_resp != 1)) || (bif.mem_req_i && (m_resp != 2))));
         if (m_owner != 0) begin
            check("bus_addr", 64'(bif.bus_addr_o), 64'(m_addr));
            check("bus_we", 64'(bif.bus_we_o), 64'(m_we));
            check("bus_be", 64'(bif.bus_be_o), 64'(m_be));
            if (m_owner == 2) check("bus_wdata", 64'(bif.bus_wdata_o), 64'(m_wdata));
         end
         if (m_resp == 1) check("if_data", 64'(bif.if_data_o), 64'(m_rdata));
         if (m_resp == 2) check("mem_rdata", 64'(bif.mem_rdata_o), 64'(m_rdata));
      end
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts rising edges from now until the requested ack is seen.
   task automatic wait_ack(input bit want_mem, output int cyc);
      cyc = 0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (want_mem ? (bif.mem_ack_o === 1'b1) : (bif.if_ack_o === 1'b1)) return;
      end
      total++;
      bad++;
      cyc = -1;
      $display("FAIL ack_wait: actual=no ack required=ack within 400 cycles");
   endtask

   task automatic wait_bus_req();
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bif.bus_req_o === 1'b1) return;
      end
      total++;
      bad++;
      $display("FAIL bus_req_wait: actual=no request required=bus_req_o within 50 cycles");
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: actual=still running required=finished");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed stimulus ----------------
   initial begin
      int cyc;
      int busy;
      int exp_order[6];
      exp_order = '{2, 2, 2, 2, 1, 2};

      bif.if_req_i    = 1'b0;
      bif.if_addr_i   = '0;
      bif.mem_req_i   = 1'b0;
      bif.mem_we_i    = 1'b0;
      bif.mem_addr_i  = '0;
      bif.mem_wdata_i = '0;
      bif.mem_be_i    = '0;

      // Reset state
      repeat (3) tick();
      @(negedge clk);
      check("rst_bus_req", 64'(bif.bus_req_o), 64'd0);
      check("rst_bus_err", 64'(bif.bus_err_o), 64'd0);
      check("rst_bus_addr", 64'(bif.bus_addr_o), 64'd0);
      check("rst_acks", 64'({bif.if_ack_o, bif.mem_ack_o}), 64'd0);
      tick();
      rst = 1'b0;
      repeat (2) tick();

      // Fetch only, slave acks one cycle after bus_req_o
      slave_lat     = 1;
      slave_data    = 32'hCAFE_F00D;
      bif.if_addr_i = 32'h100;
      bif.if_req_i  = 1'b1;
      wait_ack(1'b0, cyc);
      check("if_latency", 64'(cyc), 64'd3);
      check("if_data_lit", 64'(bif.if_data_o), 64'hCAFE_F00D);
      tick();
      bif.if_req_i = 1'b0;
      repeat (2) tick();

      // Data write: read data must come back as zero
      slave_lat       = 2;
      slave_data      = 32'h1111_2222;
      bif.mem_we_i    = 1'b1;
      bif.mem_addr_i  = 32'h2000;
      bif.mem_wdata_i = 32'hDEAD_BEEF;
      bif.mem_be_i    = 4'h3;
      bif.mem_req_i   = 1'b1;
      wait_bus_req();
      check("wr_bus_we", 64'(bif.bus_we_o), 64'd1);
      check("wr_bus_be", 64'(bif.bus_be_o), 64'h3);
      check("wr_bus_wdata", 64'(bif.bus_wdata_o), 64'hDEAD_BEEF);
      wait_ack(1'b1, cyc);
      check("wr_rdata_zero", 64'(bif.mem_rdata_o), 64'd0);
      tick();
      bif.mem_req_i = 1'b0;
      bif.mem_we_i  = 1'b0;
      repeat (2) tick();

      // Spurious slave ack while idle
      spur = 1'b1;
      tick();
      spur = 1'b0;
      @(negedge clk);
      check("spur_acks", 64'({bif.if_ack_o, bif.mem_ack_o}), 64'd0);
      check("spur_bus_req", 64'(bif.bus_req_o), 64'd0);
      tick();
      slave_lat     = 0;
      slave_data    = 32'h0000_0300;
      bif.if_addr_i = 32'h300;
      bif.if_req_i  = 1'b1;
      wait_ack(1'b0, cyc);
      check("spur_next_latency", 64'(cyc), 64'd2);
      tick();
      bif.if_req_i = 1'b0;
      repeat (2) tick();

      // Both requesters held: data wins until the starvation limit
      slave_lat      = 0;
      slave_data     = 32'h4444_5555;
      bif.mem_addr_i = 32'h4000;
      bif.if_addr_i  = 32'h500;
      grants.delete();
      bif.mem_req_i  = 1'b1;
      bif.if_req_i   = 1'b1;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (grants.size() >= 6) break;
      end
      wait_ack(1'b1, cyc);
      tick();
      bif.mem_req_i = 1'b0;
      bif.if_req_i  = 1'b0;
      check("grant_count", 64'(grants.size()), 64'd6);
      for (int i = 0; i < 6; i++) begin
         if (i < grants.size()) check("grant_order", 64'(grants[i]), 64'(exp_order[i]));
      end
      repeat (2) tick();

      // Ack in the same cycle the watchdog expires: ack wins
      slave_lat      = TMO - 1;
      slave_data     = 32'h7777_8888;
      bif.mem_addr_i = 32'h6000;
      bif.mem_req_i  = 1'b1;
      wait_ack(1'b1, cyc);
      check("edge_rdata", 64'(bif.mem_rdata_o), 64'h7777_8888);
      check("edge_no_err", 64'(bif.bus_err_o), 64'd0);
      tick();
      bif.mem_req_i = 1'b0;
      repeat (2) tick();

      // Slave never acks: abort after TMO busy cycles, sticky error
      slave_lat     = -1;
      slave_data    = 32'h9999_AAAA;
      bif.if_addr_i = 32'h700;
      bif.if_req_i  = 1'b1;
      busy = 0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (bif.bus_req_o === 1'b1) busy++;
         if (bif.if_ack_o === 1'b1) break;
      end
      check("tmo_busy_cycles", 64'(busy), 64'd255);
      check("tmo_ack", 64'(bif.if_ack_o), 64'd1);
      check("tmo_data", 64'(bif.if_data_o), 64'd0);
      check("tmo_err", 64'(bif.bus_err_o), 64'd1);
      tick();
      bif.if_req_i = 1'b0;
      repeat (2) tick();
      slave_lat     = 0;
      bif.if_addr_i = 32'h704;
      bif.if_req_i  = 1'b1;
      wait_ack(1'b0, cyc);
      check("err_sticky", 64'(bif.bus_err_o), 64'd1);
      tick();
      bif.if_req_i = 1'b0;
      repeat (2) tick();

      // Reset in the middle of a data transaction
      slave_lat      = -1;
      bif.mem_we_i   = 1'b0;
      bif.mem_addr_i = 32'h8000;
      bif.mem_req_i  = 1'b1;
      repeat (3) tick();
      rst        = 1'b1;
      slave_lat  = 1;
      slave_data = 32'hBBBB_CCCC;
      tick();
      @(negedge clk);
      check("rstmid_bus_req", 64'(bif.bus_req_o), 64'd0);
      check("rstmid_mem_ack", 64'(bif.mem_ack_o), 64'd0);
      check("rstmid_err_clr", 64'(bif.bus_err_o), 64'd0);
      tick();
      rst = 1'b0;
      wait_ack(1'b1, cyc);
      check("rstmid_latency", 64'(cyc), 64'd3);
      check("rstmid_rdata", 64'(bif.mem_rdata_o), 64'hBBBB_CCCC);
      tick();
      bif.mem_req_i = 1'b0;
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, address width of all ports.
REQ-002 Parameter DATA_W, 32, data width of all ports.
REQ-003 Parameter STARVE_LIMIT, 4, maximum consecutive data grants while fetch is pending.
REQ-004 Parameter TIMEOUT, 255, maximum BUSY cycles before abort.
REQ-005 Single clock; reset is synchronous and active-high. Ports are listed one per line: name, direction, width, meaning.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 if_req_i  in  1  instruction-fetch read request; held until if_ack_o.
REQ-009 if_addr_i  in  ADDR_W  fetch address.
REQ-010 if_data_o  out  DATA_W  fetch read data; valid only while if_ack_o=1.
REQ-011 if_ack_o  out  1  one-cycle fetch completion pulse.
REQ-012 mem_req_i  in  1  data-port request; held until mem_ack_o.
REQ-013 mem_we_i  in  1  1=write, 0=read.
REQ-014 mem_addr_i  in  ADDR_W  data address.
REQ-015 mem_wdata_i  in  DATA_W  write data.
REQ-016 mem_be_i  in  DATA_W/8  byte enables.
REQ-017 mem_rdata_o  out  DATA_W  read data; valid only while mem_ack_o=1.
REQ-018 mem_ack_o  out  1  one-cycle data completion pulse.
REQ-019 bus_req_o / bus_we_o / bus_addr_o / bus_wdata_o / bus_be_o  out  1/1/ADDR_W/DATA_W/DATA_W/8  registered shared-memory request.
REQ-020 bus_rdata_i  in  DATA_W  and bus_ack_i  in  1  slave response; bus_ack_i has variable latency.
REQ-021 hold_req_o  out  1  pipeline stall request to the ctrl block.
REQ-022 bus_err_o  out  1  sticky timeout flag.

Function
REQ-023 FSM states SHALL be IDLE, BUSY_IF, BUSY_MEM and RESP.
REQ-024 In IDLE with only one request pending, that requester SHALL be granted; when both are pending, data SHALL win unless starve_cnt==STARVE_LIMIT, in which case fetch wins.
REQ-025 On a grant, the requester's address, wdata, be and we SHALL be latched (fetch: we=0, be=all ones), and the next state SHALL be BUSY_IF or BUSY_MEM.
REQ-026 Requester inputs SHALL be ignored outside IDLE.
REQ-027 bus_req_o SHALL be 1 exactly while in BUSY_*; bus_* outputs SHALL be driven from the latched registers.
REQ-028 Sampling bus_ack_i=1 in BUSY_* SHALL capture bus_rdata_i (0 for writes) and move to RESP.
REQ-029 In RESP the granted ack_o SHALL be 1 for exactly one cycle with its data; RESP SHALL always go to IDLE.
REQ-030 Latency: request sampled at cycle 0 -> bus_req_o=1 at cycle 1; bus_ack_i at cycle k>=1 -> ack_o at k+1; earliest regrant at k+2.
REQ-031 bus_ack_i outside BUSY_* SHALL be ignored.
REQ-032 starve_cnt SHALL increment on each data grant made while if_req_i=1, saturate at STARVE_LIMIT, and clear on each fetch grant.
REQ-033 A timeout counter SHALL clear on entering BUSY_* and increment every BUSY_* cycle.
REQ-034 On reaching TIMEOUT without ack, the block SHALL go to RESP with rdata=0 and set bus_err_o, which stays set until reset.
REQ-035 An ack arriving in the same cycle the counter reaches TIMEOUT SHALL win, and no error SHALL be flagged.
REQ-036 hold_req_o SHALL be combinational: (if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o).

Reset
REQ-037 While rst=1 at a clock edge, the FSM SHALL go to IDLE and all registered outputs, counters and latches SHALL go to 0; this applies in every state.
REQ-038 Reset mid-transaction SHALL produce no ack pulse and SHALL drop bus_req_o on the next edge.

Structure
REQ-039 State encodings, STARVE_LIMIT and TIMEOUT defaults, and bus width macros SHALL reside in the shared define header.
REQ-040 The timeout counter SHALL be a sub-module named bus_timeout_cnt; all other logic SHALL be flat.

Verification
REQ-041 Fetch only: if_req_i at 0x100 with slave ack 1 cycle after bus_req_o -> if_ack_o at cycle 3, if_data_o = slave data.
REQ-042 Simultaneous requests, both held continuously -> grant order MEM, MEM, MEM, MEM, IF, MEM...
REQ-043 Data write 0xDEADBEEF with be=0x3 -> bus_we_o=1, bus_be_o=0x3, mem_ack_o pulse, mem_rdata_o=0.
REQ-044 Slave never acks -> after 255 BUSY cycles: ack with data 0 and bus_err_o=1, persisting until rst.
REQ-045 rst pulsed in BUSY_MEM -> next cycle bus_req_o=0 and no mem_ack_o; a subsequent request completes normally.
REQ-046 Spurious bus_ack_i in IDLE -> no ack_o and no state change.
